sat_add_pipe: RTL and testbench

- Multi-lane, pipelined two's-complement adder/subtractor with per-lane overflow detection.
- Result is selectable per transaction: saturated or wrap-around.
- Valid/ready handshakes on input and output, so it can sit between streaming datapath stages that apply backpressure.
- Successor to the single-lane combinational saturating adder: adds lanes, subtract mode, configurable pipeline depth and flow control.

---
 rtl/sat_add_pkg.sv | 23 ++
 rtl/sat_add_lane.sv | 33 +++
 rtl/sat_add_pipe.sv | 115 +++++++++++
 tb/tb_sat_add_pipe.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_add_pkg.sv
// Shared helpers for the saturating adder pipeline: saturation constants
// and lane slice indexing.
package sat_add_pkg;

   // Widest lane the saturation helpers can describe; callers cast down to DATAW.
   localparam int unsigned SAT_W_MAX = 256;

   // Largest positive two's-complement value of a w-bit lane: {0,1..1}.
   function automatic logic [SAT_W_MAX-1:0] sat_max(input int unsigned w);
      return (SAT_W_MAX'(1) << (w - 1)) - SAT_W_MAX'(1);
   endfunction

   // Most negative two's-complement value of a w-bit lane: {1,0..0}.
   function automatic logic [SAT_W_MAX-1:0] sat_min(input int unsigned w);
      return SAT_W_MAX'(1) << (w - 1);
   endfunction

   // Bit offset of lane k inside a flat LANES*w bus.
   function automatic int unsigned lane_lsb(input int unsigned k, input int unsigned w);
      return k * w;
   endfunction

endpackage

// File: rtl/sat_add_lane.sv
// One combinational lane: add or subtract, detect signed overflow, and
// optionally clamp to MAX/MIN.
module sat_add_lane
   import sat_add_pkg::*;
#(
   parameter int unsigned DATAW = 32
) (
   input  logic [DATAW-1:0] a,
   input  logic [DATAW-1:0] b,
   input  logic             sub,
   input  logic             sat,
   output logic [DATAW-1:0] res,
   output logic             ovf
);

   localparam int unsigned MSB = DATAW - 1;
   localparam logic [DATAW-1:0] MAX = DATAW'(sat_max(DATAW));
   localparam logic [DATAW-1:0] MIN = DATAW'(sat_min(DATAW));

   logic [DATAW-1:0] bx;
   logic [DATAW-1:0] raw;

   // Subtract as A + ~B + 1; overflow when both addends share a sign the result lacks.
   always_comb begin
      bx  = sub ? ~b : b;
      raw = a + bx + DATAW'(sub);
      ovf = (a[MSB] == bx[MSB]) && (raw[MSB] != a[MSB]);
      res = raw;
      if (sat && ovf)
         res = a[MSB] ? MIN : MAX;
   end

endmodule

// File: rtl/sat_add_pipe.sv
// Multi-lane pipelined saturating adder/subtractor with valid/ready flow
// control. Arithmetic happens before stage 1; later stages only delay.
// Optional macro SAT_ADD_PIPE_STICKY_EN adds per-lane sticky overflow flags.
module sat_add_pipe
   import sat_add_pkg::*;
#(
   parameter int unsigned DATAW  = 32,
   parameter int unsigned LANES  = 4,
   parameter int unsigned STAGES = 2
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   valid_i,
   output logic                   ready_o,
   input  logic [LANES*DATAW-1:0] dataa_i,
   input  logic [LANES*DATAW-1:0] datab_i,
   input  logic                   sub_i,
   input  logic                   sat_i,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic [LANES*DATAW-1:0] sum_o,
   output logic [LANES-1:0]       ovf_o,
   output logic [LANES-1:0]       ovf_sticky_o,
   input  logic                   ovf_clr_i
);

   // Payload carried by every pipeline stage.
   typedef struct packed {
      logic                        valid;
      logic [LANES-1:0][DATAW-1:0] data;
      logic [LANES-1:0]            ovf;
   } stage_t;

   logic [LANES-1:0][DATAW-1:0] lane_res;
   logic [LANES-1:0]            lane_ovf;
   stage_t                      in_stage;
   stage_t [STAGES:1]           pipe;
   stage_t [STAGES:0]           chain;   // chain[0] = incoming, chain[s] = stage s
   logic   [STAGES:1]           accept;  // stage s takes a new entry this cycle
   logic                        acc;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      localparam int unsigned LSB = lane_lsb(k, DATAW);
      sat_add_lane #(.DATAW(DATAW)) u_lane (
         .a   (dataa_i[LSB +: DATAW]),
         .b   (datab_i[LSB +: DATAW]),
         .sub (sub_i),
         .sat (sat_i),
         .res (lane_res[k]),
         .ovf (lane_ovf[k])
      );
   end

   // Bundle the freshly computed lanes as the stage-0 payload.
   always_comb begin
      in_stage.valid = valid_i;
      in_stage.data  = lane_res;
      in_stage.ovf   = lane_ovf;
   end

   assign chain = {pipe, in_stage};

   // A stage can load when it is empty or everything downstream of it moves.
   always_comb begin
      accept = '0;
      acc    = ready_i;
      for (int s = STAGES; s >= 1; s--) begin
         acc       = acc || !pipe[s].valid;
         accept[s] = acc;
      end
   end

   // Shift entries forward; payload registers only load behind a valid entry.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pipe <= '0;
      end else begin
         for (int s = 1; s <= STAGES; s++) begin
            if (accept[s]) begin
               pipe[s].valid <= chain[s-1].valid;
               if (chain[s-1].valid) begin
                  pipe[s].data <= chain[s-1].data;
                  pipe[s].ovf  <= chain[s-1].ovf;
               end
            end
         end
      end
   end

   assign ready_o = accept[1];
   assign valid_o = chain[STAGES].valid;
   assign sum_o   = chain[STAGES].data;
   assign ovf_o   = chain[STAGES].ovf;

`ifdef SAT_ADD_PIPE_STICKY_EN
   logic [LANES-1:0] sticky;

   // Accumulate overflow of transferred results; clear wins over a same-cycle set.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         sticky <= '0;
      else if (ovf_clr_i)
         sticky <= '0;
      else if (valid_o && ready_i)
         sticky <= sticky | ovf_o;
   end

   assign ovf_sticky_o = sticky;
`else
   logic unused_clr;
   assign unused_clr   = ovf_clr_i;
   assign ovf_sticky_o = '0;
`endif

endmodule

// File: tb/tb_sat_add_pipe.sv
// Bench for sat_add_pipe: directed scenarios on a STAGES=2 instance plus a
// randomised run on STAGES=2/1/4 instances, checked by a queue scoreboard.
module tb_sat_add_pipe;

   typedef struct packed {
      logic [15:0] sum;
      logic [1:0]  ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr;
   logic        vi [3];
   logic        ro [3];
   logic        vo [3];
   logic        ri [3];
   logic        sub [3];
   logic        sat [3];
   logic [15:0] a [3];
   logic [15:0] b [3];
   logic [15:0] sum [3];
   logic [1:0]  ovf [3];
   logic [1:0]  stk [3];

   exp_t sbq [3][$];
   int   rcv [3];
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   sat_add_pipe #(.DATAW(8), .LANES(2), .STAGES(2)) u_dut0 (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(vi[0]), .ready_o(ro[0]),
      .dataa_i(a[0]), .datab_i(b[0]), .sub_i(sub[0]), .sat_i(sat[0]),
      .valid_o(vo[0]), .ready_i(ri[0]), .sum_o(sum[0]), .ovf_o(ovf[0]),
      .ovf_sticky_o(stk[0]), .ovf_clr_i(clr));

   sat_add_pipe #(.DATAW(8), .LANES(2), .STAGES(1)) u_dut1 (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(vi[1]), .ready_o(ro[1]),
      .dataa_i(a[1]), .datab_i(b[1]), .sub_i(sub[1]), .sat_i(sat[1]),
      .valid_o(vo[1]), .ready_i(ri[1]), .sum_o(sum[1]), .ovf_o(ovf[1]),
      .ovf_sticky_o(stk[1]), .ovf_clr_i(clr));

   sat_add_pipe #(.DATAW(8), .LANES(2), .STAGES(4)) u_dut2 (
      .clk_i(clk), .rst_ni(rst_n), .valid_i(vi[2]), .ready_o(ro[2]),
      .dataa_i(a[2]), .datab_i(b[2]), .sub_i(sub[2]), .sat_i(sat[2]),
      .valid_o(vo[2]), .ready_i(ri[2]), .sum_o(sum[2]), .ovf_o(ovf[2]),
      .ovf_sticky_o(stk[2]), .ovf_clr_i(clr));

   // Reference: exact signed integer arithmetic, then range check and clamp.
   function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                  input logic s, input logic t);
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         int xa;
         int yb;
         int f;
         logic o;
         logic [7:0] r;
         xa = int'($signed(x[k*8 +: 8]));
         yb = int'($signed(y[k*8 +: 8]));
         f  = s ? (xa - yb) : (xa + yb);
         o  = (f > 127) || (f < -128);
         r  = 8'(f);
         if (t && o) r = (f > 127) ? 8'h7F : 8'h80;
         e.sum[k*8 +: 8] = r;
         e.ovf[k]        = o;
      end
      return e;
   endfunction

   function automatic logic [7:0] pick8();
      case ($urandom_range(0, 7))
         0: return 8'h7F;
         1: return 8'h80;
         2: return 8'h00;
         3: return 8'hFF;
         4: return 8'h01;
         default: return 8'($urandom);
      endcase
   endfunction

   // Scoreboard: pop/compare on output transfer, push model result on input transfer.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         for (int d = 0; d < 3; d++) begin
            if (vo[d] && ri[d]) begin
               n_cmp++;
               if (sbq[d].size() == 0) begin
                  n_bad++;
                  $display("FAIL sb_extra dut%0d: output sum=%h with nothing expected", d, sum[d]);
               end else begin
                  e = sbq[d].pop_front();
                  if ({sum[d], ovf[d]} !== {e.sum, e.ovf}) begin
                     n_bad++;
                     $display("FAIL sb_dut%0d: got sum=%h ovf=%b, want sum=%h ovf=%b",
                              d, sum[d], ovf[d], e.sum, e.ovf);
                  end
               end
               rcv[d]++;
            end
            if (vi[d] && ro[d])
               sbq[d].push_back(model(a[d], b[d], sub[d], sat[d]));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      n_cmp++; if (vo[0] !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", vo[0]); end
      n_cmp++; if (sum[0] !== 16'h0) begin n_bad++; $display("FAIL rst_sum: got %h want 0000", sum[0]); end
      n_cmp++; if (ovf[0] !== 2'b00) begin n_bad++; $display("FAIL rst_ovf: got %b want 00", ovf[0]); end
      n_cmp++; if (stk[0] !== 2'b00) begin n_bad++; $display("FAIL rst_sticky: got %b want 00", stk[0]); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      step();
      n_cmp++; if (ro[0] !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", ro[0]); end
      n_cmp++; if (vo[0] !== 1'b0) begin n_bad++; $display("FAIL rst_valid_after: got %b want 0", vo[0]); end
   endtask

   task automatic test_add();
      a[0] = {8'h7F, 8'h10}; b[0] = {8'h01, 8'h05};
      sub[0] = 1'b0; sat[0] = 1'b1; vi[0] = 1'b1; ri[0] = 1'b1;
      step();
      vi[0] = 1'b0;
      n_cmp++; if (vo[0] !== 1'b0) begin n_bad++; $display("FAIL add_lat1: valid got %b want 0", vo[0]); end
      step();
      n_cmp++; if (vo[0] !== 1'b1) begin n_bad++; $display("FAIL add_lat2: valid got %b want 1", vo[0]); end
      n_cmp++; if (sum[0] !== 16'h7F15) begin n_bad++; $display("FAIL add_sum: got %h want 7f15", sum[0]); end
      n_cmp++; if (ovf[0] !== 2'b10) begin n_bad++; $display("FAIL add_ovf: got %b want 10", ovf[0]); end
      step();
      n_cmp++; if (vo[0] !== 1'b0) begin n_bad++; $display("FAIL add_drain: valid got %b want 0", vo[0]); end
   endtask

   task automatic test_neg_sub();
      logic [15:0] ta [4];
      logic [15:0] tb [4];
      logic        ts [4];
      logic        tt [4];
      logic [15:0] es [4];
      logic [1:0]  eo [4];
      ta = '{16'h4080, 16'h0500, 16'h8000, 16'h81FF};
      tb = '{16'h40FF, 16'h0380, 16'h0180, 16'h8101};
      ts = '{1'b0, 1'b1, 1'b1, 1'b0};
      tt = '{1'b1, 1'b1, 1'b0, 1'b1};
      es = '{16'h7F80, 16'h027F, 16'h7F80, 16'h8000};
      eo = '{2'b11, 2'b01, 2'b11, 2'b10};
      ri[0] = 1'b1;
      for (int j = 0; j <= 4; j++) begin
         if (j < 4) begin
            a[0] = ta[j]; b[0] = tb[j]; sub[0] = ts[j]; sat[0] = tt[j]; vi[0] = 1'b1;
         end else begin
            vi[0] = 1'b0;
         end
         step();
         if (j >= 1) begin
            n_cmp++; if (vo[0] !== 1'b1) begin n_bad++; $display("FAIL ns_valid[%0d]: got %b want 1", j-1, vo[0]); end
            n_cmp++; if (sum[0] !== es[j-1]) begin n_bad++; $display("FAIL ns_sum[%0d]: got %h want %h", j-1, sum[0], es[j-1]); end
            n_cmp++; if (ovf[0] !== eo[j-1]) begin n_bad++; $display("FAIL ns_ovf[%0d]: got %b want %b", j-1, ovf[0], eo[j-1]); end
         end
      end
      step();
   endtask

   task automatic test_backpressure();
      int          sent = 0;
      int          got = 0;
      logic        held = 1'b0;
      logic        saw_low = 1'b0;
      logic [15:0] hs = '0;
      logic [1:0]  ho = '0;
      for (int c = 0; c < 40 && got < 6; c++) begin
         vi[0]  = (sent < 6);
         a[0]   = {8'(sent * 37), 8'h70};
         b[0]   = {8'(sent * 53), 8'(sent * 16)};
         sub[0] = sent[0];
         sat[0] = 1'b1;
         ri[0]  = !(c >= 3 && c <= 7);
         #1;
         if (held) begin
            n_cmp++;
            if ({vo[0], sum[0], ovf[0]} !== {1'b1, hs, ho}) begin
               n_bad++;
               $display("FAIL bp_hold c=%0d: got v=%b sum=%h ovf=%b want v=1 sum=%h ovf=%b",
                        c, vo[0], sum[0], ovf[0], hs, ho);
            end
         end
         if (!ro[0]) saw_low = 1'b1;
         if (vi[0] && ro[0]) sent++;
         if (vo[0] && ri[0]) got++;
         held = vo[0] && !ri[0];
         hs = sum[0];
         ho = ovf[0];
         step();
      end
      vi[0] = 1'b0; ri[0] = 1'b1;
      n_cmp++; if (saw_low !== 1'b1) begin n_bad++; $display("FAIL bp_ready_drop: got %b want 1", saw_low); end
      n_cmp++; if (sent != 6) begin n_bad++; $display("FAIL bp_sent: got %0d want 6", sent); end
      n_cmp++; if (got != 6) begin n_bad++; $display("FAIL bp_got: got %0d want 6", got); end
      n_cmp++; if (sbq[0].size() != 0) begin n_bad++; $display("FAIL bp_queue: got %0d left want 0", sbq[0].size()); end
   endtask

   task automatic test_reset_mid();
      ri[0] = 1'b1; sub[0] = 1'b0; sat[0] = 1'b0;
      a[0] = 16'h1122; b[0] = 16'h0101; vi[0] = 1'b1;
      step();
      a[0] = 16'h3344; b[0] = 16'h0202;
      step();
      vi[0] = 1'b0;
      rst_n = 1'b0;
      #1;
      sbq[0].delete();
      n_cmp++; if (vo[0] !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: got %b want 0", vo[0]); end
      n_cmp++; if (sum[0] !== 16'h0) begin n_bad++; $display("FAIL rmid_sum: got %h want 0000", sum[0]); end
      repeat (2) step();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         n_cmp++; if (vo[0] !== 1'b0) begin n_bad++; $display("FAIL rmid_stale[%0d]: valid got %b want 0", i, vo[0]); end
         n_cmp++; if (ro[0] !== 1'b1) begin n_bad++; $display("FAIL rmid_ready[%0d]: got %b want 1", i, ro[0]); end
      end
   endtask

   task automatic test_sticky();
      ri[0] = 1'b1; sub[0] = 1'b0; sat[0] = 1'b1;
      clr = 1'b1;
      step();
      clr = 1'b0;
      a[0] = 16'h007F; b[0] = 16'h0001; vi[0] = 1'b1;   // lane 0 overflows
      step();
      vi[0] = 1'b0;
      step();                                           // result at output, transfers now
      n_cmp++; if (stk[0] !== 2'b00) begin n_bad++; $display("FAIL stk_pre: got %b want 00", stk[0]); end
`ifdef SAT_ADD_PIPE_STICKY_EN
      for (int t = 6; t <= 9; t++) begin
         step();
         n_cmp++; if (stk[0] !== 2'b01) begin n_bad++; $display("FAIL stk_hold t=%0d: got %b want 01", t, stk[0]); end
      end
      clr = 1'b1;
      step();
      clr = 1'b0;
      n_cmp++; if (stk[0] !== 2'b00) begin n_bad++; $display("FAIL stk_clr: got %b want 00", stk[0]); end
      a[0] = 16'h007F; b[0] = 16'h0001; vi[0] = 1'b1;   // lane 0 overflow
      step();
      a[0] = 16'h7F00; b[0] = 16'h0100;                 // lane 1 overflow
      step();
      vi[0] = 1'b0;
      clr = 1'b1;                                       // clear with lane-0 set in same cycle
      step();
      clr = 1'b0;
      n_cmp++; if (stk[0] !== 2'b00) begin n_bad++; $display("FAIL stk_clr_prio: got %b want 00", stk[0]); end
      step();
      n_cmp++; if (stk[0] !== 2'b10) begin n_bad++; $display("FAIL stk_after_clr: got %b want 10", stk[0]); end
`else
      for (int t = 0; t < 3; t++) begin
         step();
         n_cmp++; if (stk[0] !== 2'b00) begin n_bad++; $display("FAIL stk_off t=%0d: got %b want 00", t, stk[0]); end
      end
`endif
   endtask

   task automatic test_random();
      int  sent [3];
      int  n = 10000;
      bit  done = 1'b0;
      for (int d = 0; d < 3; d++) begin
         sent[d] = 0;
         rcv[d]  = 0;
      end
      for (int cyc = 0; cyc < 40000 && !done; cyc++) begin
         for (int d = 0; d < 3; d++) begin
            vi[d]  = (sent[d] < n) && ($urandom_range(0, 3) != 0);
            a[d]   = {pick8(), pick8()};
            b[d]   = {pick8(), pick8()};
            sub[d] = 1'($urandom);
            sat[d] = 1'($urandom);
            ri[d]  = ($urandom_range(0, 3) != 0);
         end
         #1;
         for (int d = 0; d < 3; d++)
            if (vi[d] && ro[d]) sent[d]++;
         step();
         done = (rcv[0] == n) && (rcv[1] == n) && (rcv[2] == n);
      end
      for (int d = 0; d < 3; d++) begin
         vi[d] = 1'b0;
         n_cmp++; if (rcv[d] != n) begin n_bad++; $display("FAIL rnd_count dut%0d: got %0d want %0d (cycle budget)", d, rcv[d], n); end
         n_cmp++; if (sbq[d].size() != 0) begin n_bad++; $display("FAIL rnd_queue dut%0d: got %0d left want 0", d, sbq[d].size()); end
      end
   endtask

   initial begin
      clr = 1'b0;
      for (int d = 0; d < 3; d++) begin
         vi[d] = 1'b0; ri[d] = 1'b1; sub[d] = 1'b0; sat[d] = 1'b0;
         a[d] = '0; b[d] = '0; rcv[d] = 0;
      end
      test_reset();
      test_add();
      test_neg_sub();
      test_backpressure();
      test_reset_mid();
      test_sticky();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
